// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder.
// Digit limits, the digit type and the control-state encoding.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal adder with +6 correction.
// Ports: ad, bd, c in; digit, carry_out, invalid (ad or bd > 9) out.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  bcd_digit_t ad,
  input  bcd_digit_t bd,
  input  logic       c,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       invalid
);

  logic [4:0] t;

  assign t         = {1'b0, ad} + {1'b0, bd} + {4'b0, c};
  assign carry_out = t > {1'b0, BCD_MAX};
  // (t + 6)[3:0] equals t[3:0] + 6 in 4-bit arithmetic
  assign digit     = carry_out ? (t[3:0] + BCD_CORR) : t[3:0];
  assign invalid   = (ad > BCD_MAX) | (bd > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first.
// Ports: clk, rst_n, in_valid/in_ready + a, b, cin; out_valid/out_ready + sum, cout, err.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  state_e              state_q;
  logic [4*DIGITS-1:0] a_q;
  logic [4*DIGITS-1:0] b_q;
  logic [4*DIGITS-1:0] sum_q;
  logic [IDXW-1:0]     idx_q;
  logic                carry_q;
  logic                cout_q;
  logic                err_q;

  bcd_digit_t ad_s;
  bcd_digit_t bd_s;
  bcd_digit_t dig_s;
  logic       co_s;
  logic       inv_s;

  always_comb begin
    ad_s = '0;
    bd_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        ad_s = a_q[4*i +: 4];
        bd_s = b_q[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_dig (
    .ad        (ad_s),
    .bd        (bd_s),
    .c         (carry_q),
    .digit     (dig_s),
    .carry_out (co_s),
    .invalid   (inv_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) sum_q[4*i +: 4] <= dig_s;
          end
          carry_q <= co_s;
          err_q   <= err_q | inv_s;
          if (idx_q == LAST) begin
            cout_q  <= co_s;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule
